// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and status encoding for the parametrised single-clock FIFO.
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      FIFO_OK,
      FIFO_OVF,
      FIFO_UDF
   } fifo_status_e;

   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the address.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one combinational read port, no reset on the array.
module fifo_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [WIDTH-1:0]           rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost flags and sticky errors; read data one cycle after rd_ok,
// or first-word-fall-through when SYNC_FIFO_FWFT_EN is defined. Writes to a full FIFO pass only alongside a read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_wenable,
   input  logic                     i_renable,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int ADDR_W = fifo_addr_w(DEPTH);
   localparam int CNT_W  = fifo_cnt_w(DEPTH);

   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0]  AE_CNT   = CNT_W'(AE_THRESH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
   end

   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic [CNT_W-1:0]  count;
   logic              wr_ok;
   logic              rd_ok;
   logic [WIDTH-1:0]  ram_rdata;

   assign o_count        = count;
   assign o_empty        = (count == '0);
   assign o_full         = (count == FULL_CNT);
   assign o_almost_full  = (count >= AF_CNT);
   assign o_almost_empty = (count <= AE_CNT);

   // A write into a full FIFO rides on a same-cycle pop; a read never bypasses from the write port.
   assign rd_ok = i_renable && !o_empty;
   assign wr_ok = i_wenable && (!o_full || rd_ok);

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk_i),
      .wr_en   (wr_ok && !rst_i),
      .wr_addr (wptr[ADDR_W-1:0]),
      .wr_data (i_wdata),
      .rd_addr (rptr[ADDR_W-1:0]),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_ok) begin
            rptr <= rptr + PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (i_wenable && o_full && !rd_ok) begin
            o_overflow <= 1'b1;
         end
         if (i_renable && o_empty) begin
            o_underflow <= 1'b1;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign o_rdata = ram_rdata;
`else
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         o_rdata <= '0;
      end else if (rd_ok) begin
         o_rdata <= ram_rdata;
      end
   end
`endif

endmodule
